// File: rtl/pixel_pkg.sv
// Shared types and frame timing for the 2x2 image-sensor model.
package pixel_pkg;

  typedef enum logic [1:0] {
    ERASE   = 2'd0,
    EXPOSE  = 2'd1,
    CONVERT = 2'd2,
    READ    = 2'd3
  } state_e;

  localparam int C_ERASE   = 5;
  localparam int C_EXPOSE  = 100;
  localparam int C_CONVERT = 255;  // final ramp value; CONVERT lasts one cycle longer
  localparam int C_READ    = 4;

  localparam int N_PIXELS = 4;
  localparam int DATA_W   = 8;
  localparam int SEL_W    = $clog2(N_PIXELS);
  localparam int CNT_W    = 9;     // holds the longest state duration (256)

  // Number of cycles spent in each state of the frame.
  function automatic int state_len(state_e s);
    case (s)
      ERASE:   return C_ERASE;
      EXPOSE:  return C_EXPOSE;
      CONVERT: return C_CONVERT + 1;
      READ:    return C_READ;
      default: return C_ERASE;
    endcase
  endfunction

endpackage

// File: rtl/pixel_sensor.sv
// Behavioural pixel: integrates a real-valued level while exposed, digitises it
// against the shared ramp, and drives its latched code onto its bus when read.
module pixel_sensor
  import pixel_pkg::*;
#(
  parameter real DV = 0.5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              expose,
  input  logic              convert,
  input  logic              read,
  input  logic [DATA_W-1:0] ramp,
  output wire  [DATA_W-1:0] data
);

  real               level_q;
  logic              latched_q;
  logic [DATA_W-1:0] value_q;

  // Integrate during EXPOSE, latch the first ramp value reaching the level during CONVERT.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= 0.0;
      latched_q <= 1'b0;
      value_q   <= '0;
    end else if (erase) begin
      level_q   <= 0.0;
      latched_q <= 1'b0;
      value_q   <= '0;
    end else if (expose) begin
      level_q <= level_q + DV;
    end else if (convert && !latched_q) begin
      // The top ramp value catches any level above full scale, giving saturation.
      if ((real'(ramp) >= level_q) || (ramp == DATA_W'(C_CONVERT))) begin
        value_q   <= ramp;
        latched_q <= 1'b1;
      end
    end
  end

  assign data = read ? value_q : {DATA_W{1'bz}};

endmodule

// File: rtl/pixel_top.sv
// 2x2 image-sensor top: frame sequencer, shared ADC ramp, per-pixel tri-state
// buses and the registered 8-bit readout port.
module pixel_top
  import pixel_pkg::*;
#(
  parameter real DV_PIXEL = 0.5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] pixelDataOut
);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [DATA_W-1:0]               ramp_q, ramp_d;
  logic [DATA_W-1:0]               dout_q, dout_d;
  logic                            erase, expose, convert;
  logic [N_PIXELS-1:0]             read_sel;
  logic [DATA_W-1:0]               gen_data;
  logic [N_PIXELS-1:0][DATA_W-1:0] bus_val;

  // State, cycle counter, ramp and readout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ERASE;
      cnt_q   <= '0;
      ramp_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      dout_q  <= dout_d;
    end
  end

  // Next state: advance through the frame, reloading the counter on every transition.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (int'(cnt_q) == state_len(state_q) - 1) begin
      cnt_d = '0;
      case (state_q)
        ERASE:   state_d = EXPOSE;
        EXPOSE:  state_d = CONVERT;
        CONVERT: state_d = READ;
        READ:    state_d = ERASE;
        default: state_d = ERASE;
      endcase
    end
  end

  // Ramp sits at 0 outside CONVERT and climbs to full scale without wrapping.
  always_comb begin
    ramp_d = '0;
    if (state_q == CONVERT) begin
      ramp_d = (ramp_q == DATA_W'(C_CONVERT)) ? ramp_q : ramp_q + DATA_W'(1);
    end
  end

  // Control strobes decoded from the state; read strobes are one-hot within READ.
  always_comb begin
    erase    = (state_q == ERASE);
    expose   = (state_q == EXPOSE);
    convert  = (state_q == CONVERT);
    read_sel = '0;
    if (state_q == READ) begin
      read_sel = N_PIXELS'(1) << cnt_q[SEL_W-1:0];
    end
    gen_data = convert ? ramp_q : '0;
  end

  for (genvar k = 0; k < N_PIXELS; k++) begin : g_pix
    wire [DATA_W-1:0] bus;

    pixel_sensor #(
      .DV (DV_PIXEL * (k + 1))
    ) u_sensor (
      .clk     (clk),
      .reset   (reset),
      .erase   (erase),
      .expose  (expose),
      .convert (convert),
      .read    (read_sel[k]),
      .ramp    (ramp_q),
      .data    (bus)
    );

    // The ramp/data generator owns the bus whenever this pixel is not being read.
    assign bus        = read_sel[k] ? {DATA_W{1'bz}} : gen_data;
    assign bus_val[k] = bus;
  end

  // Capture the selected pixel's bus during READ; hold the last value otherwise.
  always_comb begin
    dout_d = dout_q;
    for (int k = 0; k < N_PIXELS; k++) begin
      if (read_sel[k]) dout_d = bus_val[k];
    end
  end

  assign pixelDataOut = dout_q;

endmodule

// File: tb/tb_pixel_top.sv
// Bench for pixel_top: three instances (dv 0.5, 2.0, 0.0) share clock and reset.
module tb_pixel_top;

  localparam int FRAME   = 365;
  localparam int READ_AT = 362;  // first READ edge within a frame
  localparam int EXPOSE_N = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_main, out_sat, out_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  pixel_top #(.DV_PIXEL(0.5)) dut_main (.clk(clk), .reset(reset), .pixelDataOut(out_main));
  pixel_top #(.DV_PIXEL(2.0)) dut_sat  (.clk(clk), .reset(reset), .pixelDataOut(out_sat));
  pixel_top #(.DV_PIXEL(0.0)) dut_zero (.clk(clk), .reset(reset), .pixelDataOut(out_zero));

  typedef struct {
    int         edge_no;
    logic [7:0] exp_main;
    logic [7:0] exp_sat;
    logic [7:0] exp_zero;
  } vec_t;

  vec_t vecs[14];

  // Digitised code of pixel k: smallest integer >= its integrated level, saturating.
  function automatic logic [7:0] pixel_code(real dv, int k);
    real lvl;
    lvl = dv * k * EXPOSE_N;
    if (lvl <= 0.0)   return 8'd0;
    if (lvl >= 255.0) return 8'd255;
    return 8'(int'($ceil(lvl)));
  endfunction

  // Readout value visible after edge n (counted from reset release).
  function automatic logic [7:0] model_out(real dv, int n);
    int pos, frame;
    if (n <= 0) return 8'd0;
    pos   = ((n - 1) % FRAME) + 1;
    frame = (n - 1) / FRAME;
    if (pos >= READ_AT) return pixel_code(dv, pos - READ_AT + 1);
    if (frame == 0)     return 8'd0;
    return pixel_code(dv, 4);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check_model();
    check("model_dv0.5", out_main, model_out(0.5, edge_n));
    check("model_dv2.0", out_sat,  model_out(2.0, edge_n));
    check("model_dv0.0", out_zero, model_out(0.0, edge_n));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dv0.5"}, out_main, 8'd0);
    check({name, "_dv2.0"}, out_sat,  8'd0);
    check({name, "_dv0.0"}, out_zero, 8'd0);
  endtask

  // Assert reset a few ns into the current cycle, confirm the asynchronous clear,
  // hold for some cycles, then release mid-cycle so the next edge is edge 1.
  task automatic reset_pulse(input int delay_ns, input int hold_cycles);
    #(delay_ns);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (hold_cycles) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    reset  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    vecs[0]  = '{1,   8'd0,   8'd0,   8'd0};
    vecs[1]  = '{105, 8'd0,   8'd0,   8'd0};
    vecs[2]  = '{361, 8'd0,   8'd0,   8'd0};
    vecs[3]  = '{362, 8'd50,  8'd200, 8'd0};
    vecs[4]  = '{363, 8'd100, 8'd255, 8'd0};
    vecs[5]  = '{364, 8'd150, 8'd255, 8'd0};
    vecs[6]  = '{365, 8'd200, 8'd255, 8'd0};
    vecs[7]  = '{500, 8'd200, 8'd255, 8'd0};
    vecs[8]  = '{726, 8'd200, 8'd255, 8'd0};
    vecs[9]  = '{727, 8'd50,  8'd200, 8'd0};
    vecs[10] = '{728, 8'd100, 8'd255, 8'd0};
    vecs[11] = '{729, 8'd150, 8'd255, 8'd0};
    vecs[12] = '{730, 8'd200, 8'd255, 8'd0};
    vecs[13] = '{740, 8'd200, 8'd255, 8'd0};

    // Reset held for three cycles.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset  = 1'b0;
    edge_n = 0;

    // Two full frames: fixed vectors at chosen edges, the model on every edge.
    for (int i = 0; i < 14; i++) begin
      while (edge_n < vecs[i].edge_no) begin
        step();
        check_model();
      end
      check("vec_dv0.5", out_main, vecs[i].exp_main);
      check("vec_dv2.0", out_sat,  vecs[i].exp_sat);
      check("vec_dv0.0", out_zero, vecs[i].exp_zero);
    end

    // Reset pulse during EXPOSE of a fresh frame, then a full restart.
    reset_pulse(2, 1);
    while (edge_n < 50) step();
    reset_pulse(2, 2);
    while (edge_n < 361) step();
    check("restart_pre_read", out_main, 8'd0);
    step(); check("restart_read1", out_main, 8'd50);
    step(); check("restart_read2", out_main, 8'd100);
    step(); check("restart_read3", out_main, 8'd150);
    step(); check("restart_read4", out_main, 8'd200);
    check("restart_sat4", out_sat, 8'd255);

    // Randomised reset timing, every edge compared against the model.
    for (int t = 0; t < 6; t++) begin
      int run_len;
      run_len = int'($urandom_range(1, 800));
      repeat (run_len) begin
        step();
        check_model();
      end
      reset_pulse(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
    end
    repeat (740) begin
      step();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
